// File: rtl/conv2d_relu_pool_if.sv
// Write-stream bundle (valid, address, data) shared by the conv output feeding
// the pool stage and the pool stage's write port to the pooled feature memory.
interface conv2d_relu_pool_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                 valid;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] data;

    modport master (output valid, addr, data);
    modport slave  (input  valid, addr, data);
endinterface

// File: rtl/conv2d_relu_pool.sv
// 2x2 stride-2 max-pool over a column-outer / row-fastest conv output stream.
// Define POOL_RELU_EN to clamp negative pooled maxima to zero (ReLU).
module conv2d_relu_pool #(
    parameter int DW = 32,
    parameter int H  = 32,
    parameter int AW = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    conv2d_relu_pool_if.slave  in_bus,
    conv2d_relu_pool_if.master out_bus,
    output logic               done_o,
    output logic               err_o,
    output logic               busy_o
);
    localparam int LH   = $clog2(H);
    localparam int CW   = (LH > 1) ? LH - 1 : 1;
    localparam int HALF = H / 2;

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    state_t               state;
    logic [LH-1:0]        exp_row;
    logic [LH-1:0]        exp_col;
    logic signed [DW-1:0] cbuf [HALF];
    logic signed [DW-1:0] tmp;

    logic [AW-1:0]        exp_addr;
    logic [CW-1:0]        cidx;
    logic [CW-1:0]        col_half;
    logic [AW-1:0]        pool_addr;
    logic                 active;
    logic                 accept;
    logic                 bad;
    logic                 row_last;
    logic                 col_last;

    function automatic logic signed [DW-1:0] smax(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] pool_fn(input logic signed [DW-1:0] x);
`ifdef POOL_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Upper address bits are part of the compare, so any non-zero high bit is an ordering error.
    assign exp_addr  = AW'({exp_row, exp_col});
    assign cidx      = CW'(exp_row >> 1);
    assign col_half  = CW'(exp_col >> 1);
    assign pool_addr = AW'(int'(cidx) * HALF + int'(col_half));

    // start_i wins over a coincident sample, which is then neither accepted nor flagged.
    assign active    = (state != IDLE) && !start_i && in_bus.valid;
    assign accept    = active && (in_bus.addr == exp_addr);
    assign bad       = active && (in_bus.addr != exp_addr);
    assign row_last  = (exp_row == LH'(H - 1));
    assign col_last  = (exp_col == LH'(H - 1));
    assign busy_o    = (state != IDLE);

    // NOTE: every register below is updated with <= so all reads in this edge see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            exp_row       <= '0;
            exp_col       <= '0;
            out_bus.valid <= 1'b0;
            out_bus.addr  <= '0;
            out_bus.data  <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            out_bus.valid <= 1'b0;
            done_o        <= 1'b0;
            if (start_i) begin
                state   <= EVEN;
                exp_row <= '0;
                exp_col <= '0;
                err_o   <= 1'b0;
            end else if (bad) begin
                err_o <= 1'b1;
            end else if (accept) begin
                if (row_last) begin
                    exp_row <= '0;
                    if (col_last) begin
                        exp_col <= '0;
                        state   <= IDLE;
                    end else begin
                        exp_col <= exp_col + 1'b1;
                        state   <= (state == EVEN) ? ODD : EVEN;
                    end
                end else begin
                    exp_row <= exp_row + 1'b1;
                end
                // Odd row of an odd column closes a 2x2 window.
                if (state == ODD && exp_row[0]) begin
                    out_bus.valid <= 1'b1;
                    out_bus.addr  <= pool_addr;
                    out_bus.data  <= pool_fn(smax(tmp, in_bus.data));
                    done_o        <= row_last && col_last;
                end
            end
        end
    end

    // NOTE: cbuf and tmp carry no reset; every read is preceded by a write within the same frame.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (state == EVEN) begin
                if (!exp_row[0]) begin
                    cbuf[cidx] <= in_bus.data;
                end else begin
                    cbuf[cidx] <= smax(cbuf[cidx], in_bus.data);
                end
            end else if (!exp_row[0]) begin
                tmp <= smax(cbuf[cidx], in_bus.data);
            end
        end
    end
endmodule
